// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned requests to instruction
// memory under a credit scheme and buffers in-order responses in a small FIFO
// with their PCs. A redirect flushes the buffer and drops responses that are
// still in flight for the abandoned path.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_src,
    input  logic [WIDTH-1:0] pc_target,
    output logic             imem_req_valid,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    output logic             ins_valid,
    output logic [WIDTH-1:0] ins,
    output logic [WIDTH-1:0] ins_pc,
    input  logic             ins_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [WIDTH-1:0] fetchPc_q, fetchPc_d;
    logic [WIDTH-1:0] rspPc_q, rspPc_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [CW-1:0]    dropCnt_q, dropCnt_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [0:0]       state_q, state_d;

    logic [WIDTH-1:0] pcMem_q  [DEPTH];
    logic [WIDTH-1:0] insMem_q [DEPTH];

    logic [CW:0]      occupied;
    logic             creditOk;
    logic             rspAccept;
    logic             reqFire;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] alignedTarget;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Buffered entries plus outstanding requests may never exceed the buffer
    // size, so every response always has a slot waiting for it.
    assign occupied  = {1'b0, count_q} + {1'b0, inflight_q};
    assign creditOk  = occupied < {1'b0, DEPTH_C};

    assign imem_req_valid = !rst && !pc_src && creditOk;
    assign imem_req_addr  = fetchPc_q;

    assign ins_valid = !rst && !pc_src && (count_q != '0);
    assign ins       = insMem_q[head_q];
    assign ins_pc    = pcMem_q[head_q];

    // A response with nothing outstanding (e.g. issued before a reset) is ignored.
    assign rspAccept     = imem_rsp_valid && (inflight_q != '0);
    assign reqFire       = imem_req_valid && imem_req_ready;
    assign push          = rspAccept && (dropCnt_q == '0) && !pc_src;
    assign pop           = ins_valid && ins_ready;
    assign alignedTarget = {pc_target[WIDTH-1:2], 2'b00};

    // Next-state for PCs, counters, FIFO pointers and the drain FSM.
    always_comb begin
        fetchPc_d  = fetchPc_q;
        rspPc_d    = rspPc_q;
        dropCnt_d  = dropCnt_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        state_d    = state_q;
        inflight_d = inflight_q + CW'(reqFire) - CW'(rspAccept);

        if (pc_src) begin
            fetchPc_d = alignedTarget;
            rspPc_d   = alignedTarget;
            count_d   = '0;
            head_d    = '0;
            tail_d    = '0;
            dropCnt_d = inflight_q - CW'(rspAccept);
        end else begin
            if (reqFire) begin
                fetchPc_d = fetchPc_q + WIDTH'(4);
            end
            if (push) begin
                rspPc_d = rspPc_q + WIDTH'(4);
                tail_d  = nextPtr(tail_q);
            end
            if (pop) begin
                head_d = nextPtr(head_q);
            end
            if (rspAccept && (dropCnt_q != '0)) begin
                dropCnt_d = dropCnt_q - CW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end

        case (state_q)
            FETCH:   if (dropCnt_d != '0) state_d = DRAIN;
            DRAIN:   if (dropCnt_d == '0) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Register update; reset overrides redirect and all handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q  <= RESET_PC;
            rspPc_q    <= RESET_PC;
            inflight_q <= '0;
            dropCnt_q  <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            state_q    <= FETCH;
            for (int i = 0; i < DEPTH; i++) begin
                pcMem_q[i]  <= '0;
                insMem_q[i] <= '0;
            end
        end else begin
            fetchPc_q  <= fetchPc_d;
            rspPc_q    <= rspPc_d;
            inflight_q <= inflight_d;
            dropCnt_q  <= dropCnt_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            state_q    <= state_d;
            if (push) begin
                pcMem_q[tail_q]  <= rspPc_q;
                insMem_q[tail_q] <= imem_rsp_data;
            end
        end
    end

    // A push into a full buffer means the credit accounting is broken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (count_q == DEPTH_C)));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a memory model answers requests in order, a
// scoreboard queue holds expected {pc, instruction} pairs, and a monitor
// compares every instruction the DUT hands out.
module tb_fetch_unit;

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    localparam logic [31:0] DATA_OFS = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic        pcSrc;
    logic [31:0] pcTarget;
    logic        reqValid;
    logic [31:0] reqAddr;
    logic        reqReady;
    logic        rspValid;
    logic [31:0] rspData;
    logic        insValid;
    logic [31:0] insWord;
    logic [31:0] insPc;
    logic        insReady;

    logic        reqValid2;
    logic [31:0] reqAddr2;
    logic        rspValid2;
    logic [31:0] rspData2;
    logic        insValid2;
    logic [31:0] insWord2;
    logic [31:0] insPc2;
    logic        last2Hs;
    logic [31:0] last2Addr;

    int          errors;
    int          checks;
    int          consumed;
    int unsigned cycleCnt;
    int unsigned memLat;
    logic        extraRsp;

    pend_t       pendQ[$];
    exp_t        expQ[$];
    logic [31:0] reqLog[$];
    logic [31:0] req2Log[$];

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_src         (pcSrc),
        .pc_target      (pcTarget),
        .imem_req_valid (reqValid),
        .imem_req_addr  (reqAddr),
        .imem_req_ready (reqReady),
        .imem_rsp_valid (rspValid),
        .imem_rsp_data  (rspData),
        .ins_valid      (insValid),
        .ins            (insWord),
        .ins_pc         (insPc),
        .ins_ready      (insReady)
    );

    fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
        .clk            (clk),
        .rst            (rst),
        .pc_src         (1'b0),
        .pc_target      (32'h0),
        .imem_req_valid (reqValid2),
        .imem_req_addr  (reqAddr2),
        .imem_req_ready (1'b1),
        .imem_rsp_valid (rspValid2),
        .imem_rsp_data  (rspData2),
        .ins_valid      (insValid2),
        .ins            (insWord2),
        .ins_pc         (insPc2),
        .ins_ready      (1'b1)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] timeout");
    end

    // Log request handshakes away from the clock edge and queue their responses.
    initial begin
        last2Hs   = 1'b0;
        last2Addr = '0;
        forever begin
            @(negedge clk);
            if (reqValid && reqReady) begin
                pendQ.push_back('{due: cycleCnt + memLat, addr: reqAddr});
                reqLog.push_back(reqAddr);
            end
            last2Hs   = reqValid2;
            last2Addr = reqAddr2;
            if (reqValid2) req2Log.push_back(reqAddr2);
        end
    end

    // Memory model: in-order responses, data = address + DATA_OFS.
    initial begin
        cycleCnt  = 0;
        rspValid  = 1'b0;
        rspData   = '0;
        rspValid2 = 1'b0;
        rspData2  = '0;
        forever begin
            @(posedge clk);
            cycleCnt++;
            #2;
            rspValid2 = last2Hs;
            rspData2  = last2Addr + DATA_OFS;
            if (extraRsp) begin
                rspValid = 1'b1;
                rspData  = 32'hDEAD_BEEF;
                extraRsp = 1'b0;
            end else if (pendQ.size() > 0 && pendQ[0].due <= cycleCnt) begin
                rspValid = 1'b1;
                rspData  = pendQ[0].addr + DATA_OFS;
                void'(pendQ.pop_front());
            end else begin
                rspValid = 1'b0;
                rspData  = '0;
            end
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pop the scoreboard and compare against the instruction leaving the DUT.
    task automatic checkOutput();
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_ins: got pc 0x%08h ins 0x%08h, expected no output", insPc, insWord);
        end else begin
            e = expQ.pop_front();
            consumed++;
            if (insPc !== e.pc || insWord !== e.ins) begin
                errors++;
                $display("[TB] FAIL ins_out: got pc 0x%08h ins 0x%08h expected pc 0x%08h ins 0x%08h",
                         insPc, insWord, e.pc, e.ins);
            end
        end
    endtask

    // Monitor: every accepted instruction is checked against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && insValid && insReady) checkOutput();
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic src, input logic [31:0] target,
                                 input logic rdy, input logic insRdy);
        pcSrc    = src;
        pcTarget = target;
        reqReady = rdy;
        insReady = insRdy;
    endtask

    task automatic pushExpected(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            expQ.push_back('{pc: base + 32'(4 * i), ins: base + 32'(4 * i) + DATA_OFS});
        end
    endtask

    task automatic waitConsumed(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (consumed < target && k < budget) begin
            step(1);
            k++;
        end
        checks++;
        if (consumed < target) begin
            errors++;
            $display("[TB] FAIL %s: consumed %0d instructions, needed %0d", name, consumed, target);
        end
    endtask

    // Hold reset until outstanding memory responses are gone; leaves rst=1.
    task automatic doReset();
        int k;
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step(1);
        k = 0;
        while (pendQ.size() > 0 && k < 20) begin
            step(1);
            k++;
        end
        step(1);
        expQ.delete();
        reqLog.delete();
        consumed = 0;
        memLat   = 1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        consumed = 0;
        memLat   = 1;
        extraRsp = 1'b0;
        rst      = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step(3);

        // Outputs held low while reset is asserted.
        @(negedge clk);
        checkVal("rst_ins_valid", 32'(insValid), 32'h0);
        checkVal("rst_req_valid", 32'(reqValid), 32'h0);
        step(1);

        // Streaming fetch with a 1-cycle memory.
        pushExpected(32'h0, 32);
        insReady = 1'b1;
        rst      = 1'b0;
        @(negedge clk);
        checkVal("first_req_valid", 32'(reqValid), 32'h1);
        checkVal("first_req_addr", reqAddr, 32'h0);
        checkVal("first_ins_valid", 32'(insValid), 32'h0);
        checkVal("reset_ins", insWord, 32'h0);
        checkVal("reset_ins_pc", insPc, 32'h0);
        step(1);
        @(negedge clk);
        checkVal("c1_ins_valid", 32'(insValid), 32'h0);
        step(1);
        @(negedge clk);
        checkVal("c2_ins_valid", 32'(insValid), 32'h1);
        step(1);
        waitConsumed("stream", 8, 40);

        // Consumer stalled: credit caps requests at two.
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        step(6);
        @(negedge clk);
        checkVal("stall_req_count", 32'(reqLog.size()), 32'd2);
        checkVal("stall_req0", (reqLog.size() > 0) ? reqLog[0] : 32'hFFFF_FFFF, 32'h0);
        checkVal("stall_req1", (reqLog.size() > 1) ? reqLog[1] : 32'hFFFF_FFFF, 32'h4);
        checkVal("stall_req_valid", 32'(reqValid), 32'h0);
        checkVal("stall_ins_valid", 32'(insValid), 32'h1);
        checkVal("stall_head_pc", insPc, 32'h0);
        pushExpected(32'h0, 8);
        step(1);
        insReady = 1'b1;
        waitConsumed("stall_resume", 3, 20);
        checkVal("resume_req2", (reqLog.size() > 2) ? reqLog[2] : 32'hFFFF_FFFF, 32'h8);

        // Redirect with two requests in flight: both stale responses dropped.
        doReset();
        memLat = 3;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        pushExpected(32'h100, 8);
        rst = 1'b0;
        step(2);
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
        @(negedge clk);
        checkVal("redir_inflight_reqs", 32'(reqLog.size()), 32'd2);
        checkVal("redir_req_valid", 32'(reqValid), 32'h0);
        checkVal("redir_ins_valid", 32'(insValid), 32'h0);
        step(1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        waitConsumed("redirect_drop", 2, 40);
        checkVal("redir_new_req", (reqLog.size() > 2) ? reqLog[2] : 32'hFFFF_FFFF, 32'h100);

        // Misaligned target with a full buffer: flush and align.
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        step(3);
        applyStimulus(1'b1, 32'h103, 1'b1, 1'b0);
        @(negedge clk);
        checkVal("align_redir_req_valid", 32'(reqValid), 32'h0);
        checkVal("align_redir_ins_valid", 32'(insValid), 32'h0);
        step(1);
        pushExpected(32'h100, 8);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkVal("align_req_valid", 32'(reqValid), 32'h1);
        checkVal("align_req_addr", reqAddr, 32'h100);
        step(1);
        waitConsumed("align", 2, 30);

        // Full buffer, one-cycle reset, then a stray response is ignored.
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        step(4);
        @(negedge clk);
        checkVal("full_ins_valid", 32'(insValid), 32'h1);
        checkVal("full_req_valid", 32'(reqValid), 32'h0);
        step(1);
        rst = 1'b1;
        step(1);
        rst      = 1'b0;
        extraRsp = 1'b1;
        insReady = 1'b1;
        pushExpected(32'h0, 8);
        @(negedge clk);
        checkVal("post_rst_ins_valid", 32'(insValid), 32'h0);
        checkVal("post_rst_req_valid", 32'(reqValid), 32'h1);
        checkVal("post_rst_req_addr", reqAddr, 32'h0);
        step(1);
        waitConsumed("post_reset", 2, 30);

        // Address wrap on the second instance started at 0xFFFFFFF8.
        checkVal("wrap_count_ok", 32'(req2Log.size() >= 3), 32'h1);
        checkVal("wrap_req0", (req2Log.size() > 0) ? req2Log[0] : 32'h1, 32'hFFFF_FFF8);
        checkVal("wrap_req1", (req2Log.size() > 1) ? req2Log[1] : 32'h1, 32'hFFFF_FFFC);
        checkVal("wrap_req2", (req2Log.size() > 2) ? req2Log[2] : 32'h1, 32'h0000_0000);

        insReady = 1'b0;
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
